// File: rtl/cic_comb_chain_if.sv
// Sample stream bundle for the CIC comb chain: input strobe/sync/data and
// tagged output. The master drives samples in, the slave (the comb chain) drives results out.
interface cic_comb_chain_if #(
    parameter int IW = 12,
    parameter int RW = 16,
    parameter int CW = 1
);
    logic                 i_valid;
    logic                 i_sync;
    logic signed [IW-1:0] i_data;
    logic signed [RW-1:0] o_data;
    logic                 o_valid;
    logic [CW-1:0]        o_chan;
    logic                 o_last;

    modport master (
        output i_valid, i_sync, i_data,
        input  o_data, o_valid, o_chan, o_last
    );

    modport slave (
        input  i_valid, i_sync, i_data,
        output o_data, o_valid, o_chan, o_last
    );
endinterface

// File: rtl/cic_comb_chain.sv
// N-stage pipelined CIC comb with differential delay M over C round-robin channels.
// Optional CIC_COMB_ROUND_EN: round-half-up with positive saturation on the output conversion.
module cic_comb_chain #(
    parameter int IW = 12,
    parameter int OW = 24,
    parameter int RW = 16,
    parameter int N  = 3,
    parameter int M  = 1,
    parameter int C  = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    cic_comb_chain_if.slave  if_bus
);
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int CM = C * M;
    localparam logic [CW-1:0] L_LAST = CW'(C - 1);

    logic [CW-1:0] r_chan;
    logic [CW-1:0] w_tag;

    // i_sync forces the tag of the current sample to channel 0
    assign w_tag = if_bus.i_sync ? '0 : r_chan;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_chan <= '0;
        end else if (if_bus.i_valid) begin
            r_chan <= (w_tag == L_LAST) ? '0 : w_tag + 1'b1;
        end
    end

    logic signed [OW-1:0] r_in_d;
    logic                 r_in_v;
    logic [CW-1:0]        r_in_c;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_in_d <= '0;
            r_in_v <= 1'b0;
            r_in_c <= '0;
        end else begin
            r_in_v <= if_bus.i_valid;
            if (if_bus.i_valid) begin
                r_in_d <= OW'(if_bus.i_data);
                r_in_c <= w_tag;
            end
        end
    end

    logic signed [OW-1:0] w_d [0:N-1];
    logic                 w_v [0:N-1];
    logic [CW-1:0]        w_c [0:N-1];
    logic signed [OW-1:0] w_last_diff;

    assign w_d[0] = r_in_d;
    assign w_v[0] = r_in_v;
    assign w_c[0] = r_in_c;

    for (genvar k = 1; k <= N; k++) begin : gen_stage
        logic signed [OW-1:0] r_dl [0:CM-1];
        logic signed [OW-1:0] w_diff;

        // oldest entry of the line is the same channel M samples back
        assign w_diff = w_d[k-1] - r_dl[CM-1];

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                for (int i = 0; i < CM; i++) r_dl[i] <= '0;
            end else if (w_v[k-1]) begin
                r_dl[0] <= w_d[k-1];
                for (int i = 1; i < CM; i++) r_dl[i] <= r_dl[i-1];
            end
        end

        if (k < N) begin : gen_reg
            logic signed [OW-1:0] r_q;
            logic                 r_v;
            logic [CW-1:0]        r_c;

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_q <= '0;
                    r_v <= 1'b0;
                    r_c <= '0;
                end else begin
                    r_v <= w_v[k-1];
                    if (w_v[k-1]) begin
                        r_q <= w_diff;
                        r_c <= w_c[k-1];
                    end
                end
            end

            assign w_d[k] = r_q;
            assign w_v[k] = r_v;
            assign w_c[k] = r_c;
        end else begin : gen_last
            assign w_last_diff = w_diff;
        end
    end

    logic signed [RW-1:0] w_conv;
    logic                 w_unused_bits;

    assign w_unused_bits = ^w_last_diff;

`ifdef CIC_COMB_ROUND_EN
    if (OW > RW) begin : gen_round
        localparam logic [OW:0]          L_HALF = (OW+1)'(1) << (OW - RW - 1);
        localparam logic signed [RW-1:0] L_MAX  = {1'b0, {(RW-1){1'b1}}};
        logic [OW:0] w_sum;
        logic        w_unused_sum;

        // adding a positive half-LSB can only overflow upward
        assign w_sum        = {w_last_diff[OW-1], w_last_diff} + L_HALF;
        assign w_conv       = (w_sum[OW] != w_sum[OW-1]) ? L_MAX : w_sum[OW-1:OW-RW];
        assign w_unused_sum = ^w_sum[OW-RW-1:0];
    end else begin : gen_trunc
        assign w_conv = w_last_diff[OW-1:OW-RW];
    end
`else
    assign w_conv = w_last_diff[OW-1:OW-RW];
`endif

    logic signed [RW-1:0] r_out_d;
    logic                 r_out_v;
    logic [CW-1:0]        r_out_c;
    logic                 r_out_l;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_out_d <= '0;
            r_out_v <= 1'b0;
            r_out_c <= '0;
            r_out_l <= 1'b0;
        end else begin
            r_out_v <= w_v[N-1];
            if (w_v[N-1]) begin
                r_out_d <= w_conv;
                r_out_c <= w_c[N-1];
                r_out_l <= (w_c[N-1] == L_LAST);
            end
        end
    end

    assign if_bus.o_data  = r_out_d;
    assign if_bus.o_valid = r_out_v;
    assign if_bus.o_chan  = r_out_c;
    assign if_bus.o_last  = r_out_l;
endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed bench for cic_comb_chain: four parameter sets driven from one vector
// table, a scoreboard per instance, plus reset and random-gap sequences.
module tb_cic_comb_chain;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

`ifdef CIC_COMB_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        bit rst;
        int sel;
        bit sync;
        int din;
        int exp_d;
        int exp_c;
        bit exp_l;
    } vec_t;

    typedef struct {
        int d;
        int c;
        bit l;
        int e;
    } exp_t;

    vec_t tv[$];
    exp_t q_a[$], q_b[$], q_e[$], q_d[$];
    int   ov_a = 0;

    // A: N=3 M=1 C=1 12b; B: N=1 M=1 C=2; E: N=1 M=2 C=2; D: OW=8 RW=4
    cic_comb_chain_if #(.IW(4), .RW(12), .CW(1)) if_a ();
    cic_comb_chain_if #(.IW(8), .RW(12), .CW(1)) if_b ();
    cic_comb_chain_if #(.IW(8), .RW(12), .CW(1)) if_e ();
    cic_comb_chain_if #(.IW(8), .RW(4),  .CW(1)) if_d ();

    cic_comb_chain #(.IW(4), .OW(12), .RW(12), .N(3), .M(1), .C(1)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .if_bus(if_a.slave));
    cic_comb_chain #(.IW(8), .OW(12), .RW(12), .N(1), .M(1), .C(2)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .if_bus(if_b.slave));
    cic_comb_chain #(.IW(8), .OW(12), .RW(12), .N(1), .M(2), .C(2)) u_e (
        .i_clk(clk), .i_reset_n(rst_n), .if_bus(if_e.slave));
    cic_comb_chain #(.IW(8), .OW(8), .RW(4), .N(1), .M(1), .C(1)) u_d (
        .i_clk(clk), .i_reset_n(rst_n), .if_bus(if_d.slave));

    function automatic void check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic void extra(input string nm, input int act);
        total++;
        $display("FAIL %s: unexpected o_valid with data %0d (cycle %0d)", nm, act, cyc);
    endfunction

    function automatic void add(input bit r, input int s, input bit sy, input int di,
                                input int ed, input int ec, input bit el);
        vec_t v;
        v.rst = r; v.sel = s; v.sync = sy; v.din = di;
        v.exp_d = ed; v.exp_c = ec; v.exp_l = el;
        tv.push_back(v);
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t x;
        if (if_a.o_valid) begin
            ov_a++;
            if (q_a.size() == 0) extra("A", int'(if_a.o_data));
            else begin
                x = q_a.pop_front();
                check("A data", int'(if_a.o_data), x.d);
                check("A chan", int'(if_a.o_chan), x.c);
                check("A last", int'(if_a.o_last), int'(x.l));
                check("A latency", cyc - x.e, 3);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t x;
        if (if_b.o_valid) begin
            if (q_b.size() == 0) extra("B", int'(if_b.o_data));
            else begin
                x = q_b.pop_front();
                check("B data", int'(if_b.o_data), x.d);
                check("B chan", int'(if_b.o_chan), x.c);
                check("B last", int'(if_b.o_last), int'(x.l));
                check("B latency", cyc - x.e, 1);
            end
        end
    end

    always @(negedge clk) begin : mon_e
        exp_t x;
        if (if_e.o_valid) begin
            if (q_e.size() == 0) extra("E", int'(if_e.o_data));
            else begin
                x = q_e.pop_front();
                check("E data", int'(if_e.o_data), x.d);
                check("E chan", int'(if_e.o_chan), x.c);
                check("E last", int'(if_e.o_last), int'(x.l));
                check("E latency", cyc - x.e, 1);
            end
        end
    end

    always @(negedge clk) begin : mon_d
        exp_t x;
        if (if_d.o_valid) begin
            if (q_d.size() == 0) extra("D", int'(if_d.o_data));
            else begin
                x = q_d.pop_front();
                check("D data", int'(if_d.o_data), x.d);
                check("D last", int'(if_d.o_last), int'(x.l));
                check("D latency", cyc - x.e, 1);
            end
        end
    end

    task automatic clear_inputs();
        if_a.i_valid = 1'b0; if_a.i_sync = 1'b0; if_a.i_data = '0;
        if_b.i_valid = 1'b0; if_b.i_sync = 1'b0; if_b.i_data = '0;
        if_e.i_valid = 1'b0; if_e.i_sync = 1'b0; if_e.i_data = '0;
        if_d.i_valid = 1'b0; if_d.i_sync = 1'b0; if_d.i_data = '0;
    endtask

    task automatic idle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic apply(input vec_t v);
        exp_t x;
        @(negedge clk);
        clear_inputs();
        x.d = v.exp_d; x.c = v.exp_c; x.l = v.exp_l; x.e = cyc + 1;
        case (v.sel)
            0: begin if_a.i_valid = 1'b1; if_a.i_sync = v.sync; if_a.i_data = 4'(v.din); q_a.push_back(x); end
            1: begin if_b.i_valid = 1'b1; if_b.i_sync = v.sync; if_b.i_data = 8'(v.din); q_b.push_back(x); end
            2: begin if_e.i_valid = 1'b1; if_e.i_sync = v.sync; if_e.i_data = 8'(v.din); q_e.push_back(x); end
            3: begin if_d.i_valid = 1'b1; if_d.i_sync = v.sync; if_d.i_data = 8'(v.din); q_d.push_back(x); end
            default: begin
                if_a.i_sync = 1'b1; if_b.i_sync = 1'b1; if_e.i_sync = 1'b1; if_d.i_sync = 1'b1;
            end
        endcase
    endtask

    task automatic drain();
        repeat (8) idle();
        check("A drained", q_a.size(), 0);
        check("B drained", q_b.size(), 0);
        check("E drained", q_e.size(), 0);
        check("D drained", q_d.size(), 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        q_a.delete(); q_b.delete(); q_e.delete(); q_d.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n_iv;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("A rst o_valid", int'(if_a.o_valid), 0);
        check("A rst o_data",  int'(if_a.o_data), 0);
        check("A rst o_last",  int'(if_a.o_last), 0);
        check("B rst o_valid", int'(if_b.o_valid), 0);
        check("B rst o_data",  int'(if_b.o_data), 0);
        check("B rst o_chan",  int'(if_b.o_chan), 0);
        check("B rst o_last",  int'(if_b.o_last), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // A impulse: (1 - z^-1)^3
        add(0, 0, 1, 1,  1, 0, 1);
        add(0, 0, 0, 0, -3, 0, 1);
        add(0, 0, 0, 0,  3, 0, 1);
        add(0, 0, 0, 0, -1, 0, 1);
        add(0, 0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0,  0, 0, 1);
        // A constant 5
        add(1, 0, 0, 5,   5, 0, 1);
        add(0, 0, 0, 5, -10, 0, 1);
        add(0, 0, 0, 5,   5, 0, 1);
        add(0, 0, 0, 5,   0, 0, 1);
        add(0, 0, 0, 5,   0, 0, 1);
        // B: ch0 impulse, ch1 constant 2; then lone sync, then mid-frame sync
        add(1, 1, 1, 1,  1, 0, 0);
        add(0, 1, 0, 2,  2, 1, 1);
        add(0, 1, 1, 0, -1, 0, 0);
        add(0, 1, 0, 2,  0, 1, 1);
        add(0, 1, 1, 0,  0, 0, 0);
        add(0, 1, 0, 2,  0, 1, 1);
        add(0, 1, 0, 0,  0, 0, 0);
        add(0, 4, 1, 0,  0, 0, 0);
        add(0, 1, 0, 2,  0, 1, 1);
        add(0, 1, 0, 3,  3, 0, 0);
        add(0, 1, 1, 7,  5, 0, 0);
        add(0, 1, 0, 4,  1, 1, 1);
        // E: M=2, two channels
        add(1, 2, 1, 5, 5, 0, 0);
        add(0, 2, 0, 1, 1, 1, 1);
        add(0, 2, 0, 7, 7, 0, 0);
        add(0, 2, 0, 2, 2, 1, 1);
        add(0, 2, 0, 9, 4, 0, 0);
        add(0, 2, 0, 4, 3, 1, 1);
        // D: 8b -> 4b conversion, including a wrapping difference
        add(1, 3, 0, 0,    0, 0, 1);
        add(0, 3, 0, 24,   ROUND ? 2 : 1, 0, 1);
        add(0, 3, 0, 0,    ROUND ? -1 : -2, 0, 1);
        add(0, 3, 0, 127,  7, 0, 1);
        add(0, 3, 0, -128, 0, 0, 1);

        foreach (tv[i]) begin
            if (tv[i].rst) begin
                drain();
                reset_dut();
            end
            apply(tv[i]);
        end
        drain();

        // async reset while A has a sample on its output and one in flight
        reset_dut();
        apply(tv[0]);
        apply(tv[1]);
        repeat (3) idle();
        #1;
        check("A pre-reset o_valid", int'(if_a.o_valid), 1);
        check("A pre-reset o_data",  int'(if_a.o_data), 1);
        rst_n = 1'b0;
        #1;
        check("A async o_valid", int'(if_a.o_valid), 0);
        check("A async o_data",  int'(if_a.o_data), 0);
        check("A async o_chan",  int'(if_a.o_chan), 0);
        check("A async o_last",  int'(if_a.o_last), 0);
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) apply(tv[i]);
        drain();

        // impulse again with random idle gaps between samples
        reset_dut();
        ov_a = 0;
        n_iv = 0;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 1)) idle();
            apply(tv[i]);
            n_iv++;
        end
        drain();
        check("A o_valid count", ov_a, n_iv);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule
